// File: rtl/logic_unit_pipe.sv
// Registered 8-op bitwise logic unit with OR-accumulator; 1-cycle latency, valid/ready output stage holds on stall.
// Optional zero/parity result flags are built when LOGIC_UNIT_FLAGS_EN is defined.
module logic_unit_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef LOGIC_UNIT_FLAGS_EN
  output logic             zero,
  output logic             parity,
`endif
  output logic [WIDTH-1:0] y
);

  typedef enum logic [2:0] {
    OP_AND      = 3'b000,
    OP_OR       = 3'b001,
    OP_XOR      = 3'b010,
    OP_NOR      = 3'b011,
    OP_NAND     = 3'b100,
    OP_XNOR     = 3'b101,
    OP_ACC_OR   = 3'b110,
    OP_ACC_LOAD = 3'b111
  } op_t;

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] res;
  logic             acc_we;
  logic             accept;

  // A full output register frees up in the same cycle it is drained.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    res    = '0;
    acc_we = 1'b0;
    case (op_t'(op))
      OP_AND:      res = a & b;
      OP_OR:       res = a | b;
      OP_XOR:      res = a ^ b;
      OP_NOR:      res = ~(a | b);
      OP_NAND:     res = ~(a & b);
      OP_XNOR:     res = ~(a ^ b);
      OP_ACC_OR: begin
        res    = acc | a | b;
        acc_we = 1'b1;
      end
      OP_ACC_LOAD: begin
        res    = a | b;
        acc_we = 1'b1;
      end
      default:     res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      y         <= '0;
      acc       <= '0;
`ifdef LOGIC_UNIT_FLAGS_EN
      zero      <= 1'b0;
      parity    <= 1'b0;
`endif
    end else if (accept) begin
      out_valid <= 1'b1;
      y         <= res;
      if (acc_we) acc <= res;
`ifdef LOGIC_UNIT_FLAGS_EN
      zero      <= (res == '0);
      parity    <= ^res;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
